// File: rtl/llc_lookup_stage.sv
// ---------------------------------------------------------------------------------------------
// llc_lookup_stage
//
// Purpose:
//   Sits downstream of the LLC input decoder. It pops one decoded packet from the decoder-to-mem
//   FIFO and issues a read of the tag/state arrays for that packet's set. After the fixed array
//   latency it runs the way search (lowest hit way, lowest empty way). The registered result is
//   then held for the process_request stage under a valid/ready handshake. Only one lookup is in
//   flight at a time. Idle-class packets are popped and discarded without a read.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   fifo_mem_empty/pop     decoder-to-mem FIFO status and pop strobe
//   in_class/look/set/tag  FIFO head fields (in_class is one-hot, bit 0 = idle)
//   stage_flush            abandon any in-flight lookup; wins over everything but rst
//   mem_rd_en/set          array read strobe and index
//   mem_rd_tags/states     array read data, way i at [i*W +: W]
//   out_valid/ready        result handshake
//   out_*                  registered packet fields and way-search result
//
// Optional feature:
//   Define LLC_LOOKUP_PERF_CNT_EN to add saturating hit/miss counters:
//   perf_clr (in), perf_hit_cnt (out, 32), perf_miss_cnt (out, 32).
// ---------------------------------------------------------------------------------------------
module llc_lookup_stage #(
    parameter int unsigned SET_BITS   = 9,
    parameter int unsigned TAG_BITS   = 14,
    parameter int unsigned WAYS       = 16,
    parameter int unsigned STATE_BITS = 3,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_mem_empty,
    output logic                       fifo_mem_pop,
    input  logic [9:0]                 in_class,
    input  logic                       in_look,
    input  logic [SET_BITS-1:0]        in_set,
    input  logic [TAG_BITS-1:0]        in_tag,
    input  logic                       stage_flush,
    output logic                       mem_rd_en,
    output logic [SET_BITS-1:0]        mem_rd_set,
    input  logic [WAYS*TAG_BITS-1:0]   mem_rd_tags,
    input  logic [WAYS*STATE_BITS-1:0] mem_rd_states,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [9:0]                 out_class,
    output logic [SET_BITS-1:0]        out_set,
    output logic [TAG_BITS-1:0]        out_tag,
    output logic                       out_hit,
    output logic [$clog2(WAYS)-1:0]    out_way,
    output logic [STATE_BITS-1:0]      out_hit_state,
    output logic                       out_empty_found,
    output logic [$clog2(WAYS)-1:0]    out_empty_way
`ifdef LLC_LOOKUP_PERF_CNT_EN
    ,
    input  logic                       perf_clr,
    output logic [31:0]                perf_hit_cnt,
    output logic [31:0]                perf_miss_cnt
`endif
);

    localparam int unsigned WayW = $clog2(WAYS);
    localparam int unsigned CntW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    // WAIT lasts RD_LATENCY cycles; the counter runs down to 0 on the sampling cycle.
    localparam logic [CntW-1:0] CntLoad = CntW'(RD_LATENCY - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    // Packet captured at issue, used while its read is outstanding.
    logic [9:0]          cap_class_q;
    logic [SET_BITS-1:0] cap_set_q;
    logic [TAG_BITS-1:0] cap_tag_q;
    logic                cap_look_q;

    logic                can_take;
    logic                issue;
    logic                capture;

    logic                srch_hit;
    logic [WayW-1:0]     srch_way;
    logic [STATE_BITS-1:0] srch_state;
    logic                srch_empty;
    logic [WayW-1:0]     srch_empty_way;

    // ------------------------------------------------------------------
    // Issue logic: a packet may be taken from IDLE, or from HOLD in the
    // same cycle the consumer accepts the current result.
    // ------------------------------------------------------------------
    always_comb begin
        can_take = !rst && !stage_flush && !fifo_mem_empty &&
                   ((state_q == StIdle) || ((state_q == StHold) && out_ready));
        // Idle-class packets are popped but never read.
        issue        = can_take && !in_class[0];
        fifo_mem_pop = can_take;
        mem_rd_en    = issue;
        mem_rd_set   = issue ? in_set : '0;
        out_valid    = (state_q == StHold);
        capture      = (state_q == StWait) && (cnt_q == '0) && !stage_flush;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (issue) begin
                    state_d = StWait;
                    cnt_d   = CntLoad;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                if (out_ready) begin
                    if (issue) begin
                        state_d = StWait;
                        cnt_d   = CntLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (stage_flush) begin
            state_d = StIdle;
        end
    end

    // ------------------------------------------------------------------
    // Way search. Scanning from the top down lets the lowest index win
    // for both the hit and the empty-way result.
    // ------------------------------------------------------------------
    always_comb begin
        srch_hit       = 1'b0;
        srch_way       = '0;
        srch_state     = '0;
        srch_empty     = 1'b0;
        srch_empty_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (cap_look_q &&
                (mem_rd_tags[i*TAG_BITS +: TAG_BITS] == cap_tag_q) &&
                (mem_rd_states[i*STATE_BITS +: STATE_BITS] != '0)) begin
                srch_hit   = 1'b1;
                srch_way   = WayW'(i);
                srch_state = mem_rd_states[i*STATE_BITS +: STATE_BITS];
            end
            if (mem_rd_states[i*STATE_BITS +: STATE_BITS] == '0) begin
                srch_empty     = 1'b1;
                srch_empty_way = WayW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // State and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            cap_class_q     <= '0;
            cap_set_q       <= '0;
            cap_tag_q       <= '0;
            cap_look_q      <= 1'b0;
            out_class       <= '0;
            out_set         <= '0;
            out_tag         <= '0;
            out_hit         <= 1'b0;
            out_way         <= '0;
            out_hit_state   <= '0;
            out_empty_found <= 1'b0;
            out_empty_way   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (issue) begin
                cap_class_q <= in_class;
                cap_set_q   <= in_set;
                cap_tag_q   <= in_tag;
                cap_look_q  <= in_look;
            end
            // Outputs change only when a new result lands; they hold otherwise.
            if (capture) begin
                out_class       <= cap_class_q;
                out_set         <= cap_set_q;
                out_tag         <= cap_tag_q;
                out_hit         <= srch_hit;
                out_way         <= srch_way;
                out_hit_state   <= srch_state;
                out_empty_found <= srch_empty;
                out_empty_way   <= srch_empty_way;
            end
        end
    end

`ifdef LLC_LOOKUP_PERF_CNT_EN
    // cap_look_q still belongs to the held packet during the handshake cycle:
    // a following issue only overwrites it at the closing edge.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
        end else if (out_valid && out_ready && cap_look_q) begin
            if (out_hit) begin
                if (perf_hit_cnt != 32'hFFFF_FFFF) begin
                    perf_hit_cnt <= perf_hit_cnt + 32'd1;
                end
            end else begin
                if (perf_miss_cnt != 32'hFFFF_FFFF) begin
                    perf_miss_cnt <= perf_miss_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_llc_lookup_stage.sv
// ---------------------------------------------------------------------------------------------
// tb_llc_lookup_stage
//
// Directed bench for llc_lookup_stage at default parameters. A small FIFO model feeds the
// decoder-side inputs, and an array model returns the set's contents exactly two cycles after
// mem_rd_en and a junk pattern otherwise. Inputs change 1 time unit after the rising edge and
// outputs are checked on the falling edge.
// ---------------------------------------------------------------------------------------------
module tb_llc_lookup_stage;

    localparam int unsigned SET_BITS   = 9;
    localparam int unsigned TAG_BITS   = 14;
    localparam int unsigned WAYS       = 16;
    localparam int unsigned STATE_BITS = 3;

    logic                       clk;
    logic                       rst;
    logic                       fifo_mem_empty;
    logic                       fifo_mem_pop;
    logic [9:0]                 in_class;
    logic                       in_look;
    logic [SET_BITS-1:0]        in_set;
    logic [TAG_BITS-1:0]        in_tag;
    logic                       stage_flush;
    logic                       mem_rd_en;
    logic [SET_BITS-1:0]        mem_rd_set;
    logic [WAYS*TAG_BITS-1:0]   mem_rd_tags;
    logic [WAYS*STATE_BITS-1:0] mem_rd_states;
    logic                       out_valid;
    logic                       out_ready;
    logic [9:0]                 out_class;
    logic [SET_BITS-1:0]        out_set;
    logic [TAG_BITS-1:0]        out_tag;
    logic                       out_hit;
    logic [3:0]                 out_way;
    logic [STATE_BITS-1:0]      out_hit_state;
    logic                       out_empty_found;
    logic [3:0]                 out_empty_way;

    int    tests = 0;
    int    fails = 0;
    string step  = "init";

    llc_lookup_stage dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_mem_empty  (fifo_mem_empty),
        .fifo_mem_pop    (fifo_mem_pop),
        .in_class        (in_class),
        .in_look         (in_look),
        .in_set          (in_set),
        .in_tag          (in_tag),
        .stage_flush     (stage_flush),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_set      (mem_rd_set),
        .mem_rd_tags     (mem_rd_tags),
        .mem_rd_states   (mem_rd_states),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_class       (out_class),
        .out_set         (out_set),
        .out_tag         (out_tag),
        .out_hit         (out_hit),
        .out_way         (out_way),
        .out_hit_state   (out_hit_state),
        .out_empty_found (out_empty_found),
        .out_empty_way   (out_empty_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- FIFO model ----------------
    logic [9:0]          f_class [16];
    logic                f_look  [16];
    logic [SET_BITS-1:0] f_set   [16];
    logic [TAG_BITS-1:0] f_tag   [16];
    logic [7:0]          wr_ptr = '0;
    logic [7:0]          rd_ptr = '0;

    assign fifo_mem_empty = (rd_ptr == wr_ptr);
    assign in_class       = f_class[rd_ptr[3:0]];
    assign in_look        = f_look[rd_ptr[3:0]];
    assign in_set         = f_set[rd_ptr[3:0]];
    assign in_tag         = f_tag[rd_ptr[3:0]];

    always @(posedge clk) begin
        if (fifo_mem_pop) rd_ptr <= rd_ptr + 8'd1;
    end

    // ---------------- Array model (latency 2) ----------------
    logic [WAYS*TAG_BITS-1:0]   tag_mem [512];
    logic [WAYS*STATE_BITS-1:0] st_mem  [512];
    logic                       pv0 = 1'b0;
    logic                       pv1 = 1'b0;
    logic [SET_BITS-1:0]        ps0 = '0;
    logic [SET_BITS-1:0]        ps1 = '0;

    always @(posedge clk) begin
        pv0 <= mem_rd_en;
        ps0 <= mem_rd_set;
        pv1 <= pv0;
        ps1 <= ps0;
    end

    assign mem_rd_tags   = pv1 ? tag_mem[ps1] : {(WAYS*TAG_BITS){1'b1}};
    assign mem_rd_states = pv1 ? st_mem[ps1]  : {WAYS{3'b001}};

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s: got 0x%0h, expected 0x%0h", step, tag, obs, exp);
        end
    endtask

    task automatic push(input logic [9:0] c, input logic l, input logic [SET_BITS-1:0] s,
                        input logic [TAG_BITS-1:0] t);
        f_class[wr_ptr[3:0]] = c;
        f_look[wr_ptr[3:0]]  = l;
        f_set[wr_ptr[3:0]]   = s;
        f_tag[wr_ptr[3:0]]   = t;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic set_way(input int s, input int w, input logic [TAG_BITS-1:0] t,
                           input logic [STATE_BITS-1:0] st);
        tag_mem[s][w*TAG_BITS +: TAG_BITS]     = t;
        st_mem[s][w*STATE_BITS +: STATE_BITS] = st;
    endtask

    task automatic chk_out(input logic [9:0] c, input logic [SET_BITS-1:0] s,
                           input logic [TAG_BITS-1:0] t, input logic h, input logic [3:0] w,
                           input logic [2:0] hs, input logic ef, input logic [3:0] ew);
        chk("out_class", out_class, c);
        chk("out_set", out_set, s);
        chk("out_tag", out_tag, t);
        chk("out_hit", out_hit, h);
        chk("out_way", out_way, w);
        chk("out_hit_state", out_hit_state, hs);
        chk("out_empty_found", out_empty_found, ef);
        chk("out_empty_way", out_empty_way, ew);
    endtask

    // Single isolated packet: pop in cycle 1, result in cycle 4, valid drops in cycle 5.
    task automatic one_pkt(input string name, input logic [9:0] c, input logic l,
                           input logic [SET_BITS-1:0] s, input logic [TAG_BITS-1:0] t,
                           input logic h, input logic [3:0] w, input logic [2:0] hs,
                           input logic ef, input logic [3:0] ew);
        step = name;
        tick();
        push(c, l, s, t);
        at_neg();
        chk("pop_c1", fifo_mem_pop, 1);
        chk("rd_en_c1", mem_rd_en, 1);
        chk("rd_set_c1", mem_rd_set, s);
        chk("valid_c1", out_valid, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            at_neg();
            chk("valid_wait", out_valid, 0);
            chk("rd_en_wait", mem_rd_en, 0);
            chk("pop_wait", fifo_mem_pop, 0);
        end
        tick();
        at_neg();
        chk("valid_c4", out_valid, 1);
        chk_out(c, s, t, h, w, hs, ef, ew);
        tick();
        at_neg();
        chk("valid_c5", out_valid, 0);
    endtask

    // Back-to-back stimulus expectations.
    logic       b2b_hit [4];
    logic [3:0] b2b_way [4];

    initial begin
        rst         = 1'b1;
        stage_flush = 1'b0;
        out_ready   = 1'b1;

        // Set 5: way 3 holds 0x1234 (state 2); way 0 also has 0x1234 but is INVALID.
        for (int i = 0; i < 16; i++) set_way(5, i, 14'h100 + 14'(i), 3'd1);
        set_way(5, 0, 14'h1234, 3'd0);
        set_way(5, 1, 14'h101, 3'd0);
        set_way(5, 3, 14'h1234, 3'd2);
        // Set 6: every way valid, no 0x1234.
        for (int i = 0; i < 16; i++) set_way(6, i, 14'h200 + 14'(i), 3'd3);
        // Set 7: duplicate 0xABC in ways 5 and 9; only way 12 empty.
        for (int i = 0; i < 16; i++) set_way(7, i, 14'h300 + 14'(i), 3'd1);
        set_way(7, 5, 14'hABC, 3'd4);
        set_way(7, 9, 14'hABC, 3'd6);
        set_way(7, 12, 14'h30C, 3'd0);

        // ---- reset ----
        step = "reset";
        tick();
        at_neg();
        chk("valid", out_valid, 0);
        chk("pop", fifo_mem_pop, 0);
        chk("rd_en", mem_rd_en, 0);
        chk("hit", out_hit, 0);
        chk("empty_found", out_empty_found, 0);
        tick();
        rst = 1'b0;
        at_neg();
        chk("valid_idle", out_valid, 0);

        // ---- single lookups ----
        one_pkt("hit_look1", 10'h020, 1'b1, 9'h05, 14'h1234, 1'b1, 4'd3, 3'd2, 1'b1, 4'd0);
        one_pkt("look0", 10'h020, 1'b0, 9'h05, 14'h1234, 1'b0, 4'd0, 3'd0, 1'b1, 4'd0);
        one_pkt("all_valid_miss", 10'h040, 1'b1, 9'h06, 14'h1234, 1'b0, 4'd0, 3'd0,
                1'b0, 4'd0);
        one_pkt("multi_hit", 10'h008, 1'b1, 9'h07, 14'h0ABC, 1'b1, 4'd5, 3'd4, 1'b1, 4'd12);

        // ---- back-to-back, consumer always ready ----
        step = "b2b";
        b2b_hit = '{1'b1, 1'b0, 1'b1, 1'b0};
        b2b_way = '{4'd3, 4'd0, 4'd5, 4'd0};
        tick();
        push(10'h020, 1'b1, 9'h05, 14'h1234);
        push(10'h020, 1'b1, 9'h06, 14'h1234);
        push(10'h020, 1'b1, 9'h07, 14'h0ABC);
        push(10'h020, 1'b0, 9'h05, 14'h1234);
        for (int r = 1; r <= 14; r++) begin
            if (r > 1) tick();
            at_neg();
            chk("pop", fifo_mem_pop, ((r <= 10) && ((r - 1) % 3 == 0)) ? 1 : 0);
            chk("rd_en", mem_rd_en, ((r <= 10) && ((r - 1) % 3 == 0)) ? 1 : 0);
            chk("valid", out_valid, ((r >= 4) && ((r - 1) % 3 == 0)) ? 1 : 0);
            if ((r >= 4) && ((r - 1) % 3 == 0)) begin
                chk("hit", out_hit, b2b_hit[(r - 4) / 3]);
                chk("way", out_way, b2b_way[(r - 4) / 3]);
            end
        end

        // ---- backpressure ----
        step = "backpressure";
        tick();
        out_ready = 1'b0;
        push(10'h020, 1'b1, 9'h05, 14'h1234);
        push(10'h010, 1'b1, 9'h07, 14'h0ABC);
        at_neg();
        chk("pop_c1", fifo_mem_pop, 1);
        tick();
        tick();
        for (int r = 4; r <= 8; r++) begin
            tick();
            at_neg();
            chk("valid_hold", out_valid, 1);
            chk("pop_hold", fifo_mem_pop, 0);
            chk("rd_en_hold", mem_rd_en, 0);
            chk("way_hold", out_way, 3);
            chk("tag_hold", out_tag, 14'h1234);
        end
        tick();
        out_ready = 1'b1;
        at_neg();
        chk("pop_release", fifo_mem_pop, 1);
        chk("rd_en_release", mem_rd_en, 1);
        chk("rd_set_release", mem_rd_set, 9'h07);
        tick();
        tick();
        tick();
        at_neg();
        chk("valid_2nd", out_valid, 1);
        chk_out(10'h010, 9'h07, 14'h0ABC, 1'b1, 4'd5, 3'd4, 1'b1, 4'd12);
        tick();
        at_neg();
        chk("valid_idle", out_valid, 0);

        // ---- flush during WAIT ----
        step = "flush";
        tick();
        push(10'h020, 1'b1, 9'h05, 14'h1234);
        push(10'h020, 1'b1, 9'h06, 14'h0123);
        at_neg();
        chk("pop_c1", fifo_mem_pop, 1);
        tick();
        stage_flush = 1'b1;
        at_neg();
        chk("pop_c2", fifo_mem_pop, 0);
        chk("rd_en_c2", mem_rd_en, 0);
        tick();
        stage_flush = 1'b0;
        at_neg();
        chk("pop_c3", fifo_mem_pop, 1);
        chk("rd_en_c3", mem_rd_en, 1);
        chk("rd_set_c3", mem_rd_set, 9'h06);
        chk("valid_c3", out_valid, 0);
        for (int r = 4; r <= 5; r++) begin
            tick();
            at_neg();
            chk("valid_wait", out_valid, 0);
        end
        tick();
        at_neg();
        chk("valid_c6", out_valid, 1);
        chk_out(10'h020, 9'h06, 14'h0123, 1'b0, 4'd0, 3'd0, 1'b0, 4'd0);
        // Flush in IDLE with a packet waiting blocks the pop.
        tick();
        stage_flush = 1'b1;
        push(10'h020, 1'b1, 9'h07, 14'h0ABC);
        at_neg();
        chk("pop_flush_idle", fifo_mem_pop, 0);
        chk("rd_en_flush_idle", mem_rd_en, 0);
        tick();
        stage_flush = 1'b0;
        at_neg();
        chk("pop_after_flush", fifo_mem_pop, 1);
        tick();
        tick();
        tick();
        at_neg();
        chk("valid_after_flush", out_valid, 1);
        chk("way_after_flush", out_way, 5);

        // ---- idle-class packet discarded, next packet follows ----
        step = "idle_class";
        tick();
        push(10'h001, 1'b1, 9'h08, 14'h0555);
        push(10'h020, 1'b1, 9'h05, 14'h1234);
        at_neg();
        chk("pop_idle", fifo_mem_pop, 1);
        chk("rd_en_idle", mem_rd_en, 0);
        chk("valid_c1", out_valid, 0);
        tick();
        at_neg();
        chk("pop_next", fifo_mem_pop, 1);
        chk("rd_en_next", mem_rd_en, 1);
        chk("rd_set_next", mem_rd_set, 9'h05);
        chk("valid_c2", out_valid, 0);
        for (int r = 3; r <= 4; r++) begin
            tick();
            at_neg();
            chk("valid_wait", out_valid, 0);
        end
        tick();
        at_neg();
        chk("valid_c5", out_valid, 1);
        chk_out(10'h020, 9'h05, 14'h1234, 1'b1, 4'd3, 3'd2, 1'b1, 4'd0);

        // ---- reset during WAIT ----
        step = "reset_wait";
        tick();
        push(10'h020, 1'b1, 9'h07, 14'h0ABC);
        at_neg();
        chk("pop_c1", fifo_mem_pop, 1);
        tick();
        rst = 1'b1;
        at_neg();
        chk("pop_rst", fifo_mem_pop, 0);
        tick();
        rst = 1'b0;
        at_neg();
        chk("fifo_drained", fifo_mem_empty, 1);
        chk("pop_after_rst", fifo_mem_pop, 0);
        chk("way_cleared", out_way, 0);
        chk("hit_cleared", out_hit, 0);
        chk("tag_cleared", out_tag, 0);
        for (int r = 4; r <= 6; r++) begin
            tick();
            at_neg();
            chk("valid_after_rst", out_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
